// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   * op-code constants driven by the instruction decoder onto md_unit.op
//   * FSM state encoding (also visible on md_unit.state_o)
//   * mag32: two's-complement magnitude helper used for operand preparation
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    // Magnitude of v when it is to be treated as signed; 32'h80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit -- iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   rst      in   asynchronous active-low reset
//   start    in   request strobe
//   op       in   3-bit operation (MD_MULT..MD_MTLO, 110/111 reserved)
//   a, b     in   32-bit operands (rs, rt)
//   busy     out  iterative operation in progress (CALC or FIN)
//   done     out  one-cycle pulse in the cycle after HI/LO were written
//   hi, lo   out  HI/LO registers
//   state_o  out  current FSM state (md_state_e encoding), for observation
//
// Handshake: start is sampled on every posedge but only acted on while the
// FSM is in IDLE (busy=0); a start seen while busy=1 is dropped without
// effect. Every accepted multiply/divide/MTHI/MTLO produces exactly one done
// pulse, and hi/lo are valid to read in that done cycle. Because done is
// produced while the FSM is already back in IDLE, a new start may be
// presented in the done cycle.
//
// Multiply and divide share one 64-bit accumulator: 32 CALC cycles of
// shift-add (multiply) or restoring shift-subtract (divide) on operand
// magnitudes, then one FIN cycle for the sign fix-up and the HI/LO write.
module md_unit
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_o
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Datapath helpers derived from the latched operation.
    logic        signed_op;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
        is_div    = op_q[1];
        neg_a     = signed_op & a_q[31];
        neg_b     = signed_op & b_q[31];
        mag_b     = mag32(b_q, signed_op);

        // Multiply: acc = {partial, multiplier}; add multiplicand into the
        // upper half when the multiplier LSB is set, then shift right with
        // the carry moving into bit 63.
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // Divide: acc = {remainder, dividend/quotient}; shift left one and
        // keep the trial subtraction only when it did not borrow.
        div_trial = acc_q[63:31] - {1'b0, mag_b};
        div_next  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                  : {div_trial[31:0], acc_q[30:0], 1'b1};

        // Sign fix-up: product and quotient negative when operand signs
        // differ; remainder follows the dividend.
        prod_fix = (neg_a ^ neg_b) ? (64'd0 - acc_q) : acc_q;
        quot_fix = (neg_a ^ neg_b) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = neg_a ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = 5'd0;
                        acc_d   = {32'd0, mag32(a, (op == MD_MULT) || (op == MD_DIV))};
                        state_d = ST_CALC;
                    end else if (op == MD_MTHI) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == MD_MTLO) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div ? div_next : mul_next;
                // 5-bit counter wraps 31->0 as CALC ends.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (!is_div) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (b_q == 32'd0) begin
                    // Divide by zero yields a defined result, no trap.
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    // 0x80000000 / -1 falls out as quotient 0x80000000,
                    // remainder 0 from the magnitude path.
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == ST_CALC) || (state_q == ST_FIN);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- self-checking bench for md_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  state_o;

    md_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model built on the simulator's own arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sx, sy;
        int     ix, iy;
        logic [63:0] r;
        r = {h, l};
        case (o)
            MD_MULT: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                r  = 64'(sx * sy);
            end
            MD_MULTU: r = {32'd0, x} * {32'd0, y};
            MD_DIV: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    ix = x;
                    iy = y;
                    r  = {32'(ix % iy), 32'(ix / iy)};
                end
            end
            MD_DIVU: r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            MD_MTHI: r = {x, l};
            MD_MTLO: r = {h, x};
            default: r = {h, l};
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] e, input bit push);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles and checking that HI/LO
    // hold meanwhile; then pops and compares the expected result.
    task automatic wait_done(input string name, input int exp_busy);
        int          busy_cnt = 0;
        int          n = 0;
        logic [63:0] e;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            check({name, " hold"}, {hi, lo}, {m_hi, m_lo});
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done not seen within 100 cycles", name);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
            check({name, " busy at done"}, 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: done with empty expected queue", name);
            end else begin
                e = exp_q.pop_front();
                check({name, " result"}, {hi, lo}, e);
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] e, input int exp_busy);
        issue(o, x, y, e, 1'b1);
        wait_done(name, exp_busy);
        @(negedge clk);
        check({name, " done width"}, 64'(done), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6]  = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[7]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset state", 64'(state_o), 64'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                {vecs[i].hi, vecs[i].lo}, 33);
        end

        // MTHI / MTLO: written at the accepting edge, no busy cycles
        run("mthi", MD_MTHI, 32'h1234_5678, 32'd0, model(MD_MTHI, 32'h1234_5678, 32'd0, m_hi, m_lo), 0);
        run("mtlo", MD_MTLO, 32'hCAFE_F00D, 32'd0, model(MD_MTLO, 32'hCAFE_F00D, 32'd0, m_hi, m_lo), 0);

        // Reserved op codes are ignored
        for (int r = 6; r < 8; r++) begin
            issue(3'(r), 32'hDEAD_BEEF, 32'd1, 64'd0, 1'b0);
            check("reserved done", 64'(done), 64'd0);
            check("reserved busy", 64'(busy), 64'd0);
            check("reserved hilo", {hi, lo}, {m_hi, m_lo});
        end

        // Random multiply/divide against the model
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 3));
            x = $urandom;
            y = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (y == 32'd0) y = 32'd1;
            run($sformatf("rand%0d", i), o, x, y, model(o, x, y, m_hi, m_lo), 33);
        end

        // start while busy is ignored
        issue(MD_DIVU, 32'd1000, 32'd7, model(MD_DIVU, 32'd1000, 32'd7, m_hi, m_lo), 1'b1);
        repeat (10) @(negedge clk);
        issue(MD_MULT, 32'h0000_1111, 32'h0000_2222, 64'd0, 1'b0);
        wait_done("busy ignore", 22);
        @(negedge clk);
        check("busy ignore idle after", 64'(busy), 64'd0);
        check("busy ignore done width", 64'(done), 64'd0);

        // start in the done cycle is accepted
        issue(MD_MULTU, 32'd12345, 32'd678, model(MD_MULTU, 32'd12345, 32'd678, m_hi, m_lo), 1'b1);
        wait_done("b2b first", 33);
        issue(MD_DIV, 32'hFFFF_FC18, 32'd7, model(MD_DIV, 32'hFFFF_FC18, 32'd7, m_hi, m_lo), 1'b1);
        wait_done("b2b second", 33);
        @(negedge clk);

        // Reset mid-CALC aborts the operation
        issue(MD_MULT, 32'h0000_0123, 32'h0000_0456, 64'd0, 1'b1);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        check("abort state", 64'(state_o), 64'(ST_IDLE));
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("abort no done", 64'(seen), 64'd0);
            check("abort hilo hold", {hi, lo}, 64'd0);
        end

        // First edge after reset release accepts a start
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(MD_MULTU, 32'h0000_FFFF, 32'h0001_0001, model(MD_MULTU, 32'h0000_FFFF, 32'h0001_0001, m_hi, m_lo), 1'b1);
        wait_done("post reset", 33);
        @(negedge clk);

        check("queue empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  request strobe, sampled on posedge clk.
REQ-005 op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 a  in  32  operand rs: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  in  32  operand rt: multiplier or divisor.
REQ-008 busy  out  1  high while an iterative operation is in progress.
REQ-009 done  out  1  one-cycle registered pulse; high in the cycle after HI/LO update.
REQ-010 hi  out  32  HI register, registered, feeds the register-file write-data mux for MFHI.
REQ-011 lo  out  32  LO register, registered, feeds the register-file write-data mux for MFLO.

Function
REQ-012 FSM states: IDLE, CALC, FIN; reset state IDLE.
REQ-013 In IDLE, start=1 with op in {000..011} latches a, b and op, clears the 5-bit iteration counter, and moves to CALC.
REQ-014 In IDLE, start=1 with op=100 writes hi<=a (or op=101 writes lo<=a) at that edge, sets done for one cycle, and stays in IDLE; busy stays 0.
REQ-015 In IDLE, start=1 with op 110/111 is ignored: no state change, no done.
REQ-016 CALC lasts exactly 32 cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes; the counter wraps 31->0 into FIN.
REQ-017 FIN lasts 1 cycle, applies the sign fix-up, writes hi/lo, sets done=1 for the next cycle, and returns to IDLE.
REQ-018 Latency: start accepted at edge E0; busy=1 from E0 through E33; hi/lo change only at E33; done=1 and busy=0 in the cycle after E33.
REQ-019 MULT/MULTU: {hi,lo} = full 64-bit product, signed (two's complement) or unsigned respectively.
REQ-020 DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-021 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-022 Divide by zero (b=0, DIV or DIVU): hi=a, lo=32'hFFFFFFFF; no exception is raised.
REQ-023 DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
REQ-024 start while busy=1 is ignored; the latched operands and op do not change.
REQ-025 A new start is accepted in the same cycle that done=1, because the FSM is already in IDLE.
REQ-026 hi/lo hold their value at all times other than the REQ-014 and REQ-017 write edges.

Reset
REQ-027 rst=0 asynchronously forces state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and clears all internal operand/accumulator registers.
REQ-028 Reset asserted mid-CALC or mid-FIN aborts the operation; no done pulse is produced and hi/lo read 0 after reset.
REQ-029 After rst deasserts, the first posedge is able to accept a start.

Structure
REQ-030 Shared package md_pkg holds the op-code constants (MD_MULT..MD_MTLO) and the FSM state encoding; the decoder that drives op/start imports the same package.
REQ-031 Single module, no sub-modules; one 64-bit shared accumulator/remainder-quotient register serves both multiply and divide.
REQ-032 busy is a decode of state (CALC or FIN), with no extra flop; done is a flop.

Verification
REQ-033 MULT a=32'hFFFFFFFE (-2), b=3 -> after 33 busy cycles, hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulse of exactly 1 cycle.
REQ-034 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-035 DIV a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU a=7, b=0 -> hi=7, lo=32'hFFFFFFFF.
REQ-036 DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0; MTHI a=32'h12345678 -> hi updated at the accepting edge, done next cycle, busy never 1.
REQ-037 start with a second op pulsed at cycle 10 of a DIVU -> ignored, result matches the first op; start in the done cycle -> accepted.
REQ-038 rst=0 at cycle 20 of a MULT -> busy=0, done=0, hi=lo=0 immediately; no done pulse follows.
